// File: rtl/approx_err_monitor.sv
// Exhaustive-sweep error evaluator: walks every input vector through an approximate
// and an exact combinational circuit and accumulates max, count and sum of |error|.
module approx_err_monitor #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 2,
   parameter int ET    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic [N_IN-1:0]       vec_out,
   input  logic [N_OUT-1:0]      approx_in,
   input  logic [N_OUT-1:0]      exact_in,
   output logic                  busy,
   output logic                  done,
   output logic [N_OUT-1:0]      max_err,
   output logic [N_IN:0]         err_count,
   output logic [N_IN+N_OUT-1:0] sum_err,
   output logic                  pass
);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [N_OUT:0] ET_W = (N_OUT+1)'(ET);

   state_t                  state, state_nxt;
   logic [N_IN-1:0]         vec_nxt;
   logic                    busy_nxt, done_nxt, pass_nxt;
   logic [N_OUT-1:0]        max_nxt;
   logic [N_IN:0]           cnt_nxt;
   logic [N_IN+N_OUT-1:0]   sum_nxt;

   logic [N_OUT-1:0]        err_mag;
   logic [N_OUT-1:0]        max_upd;

   // The guarded subtraction never underflows, so the magnitude fits N_OUT bits.
   always_comb begin
      err_mag = (approx_in >= exact_in) ? (approx_in - exact_in) : (exact_in - approx_in);
      max_upd = (err_mag > max_err) ? err_mag : max_err;
   end

   always_comb begin
      state_nxt = state;
      vec_nxt   = vec_out;
      busy_nxt  = busy;
      done_nxt  = done;
      pass_nxt  = pass;
      max_nxt   = max_err;
      cnt_nxt   = err_count;
      sum_nxt   = sum_err;

      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = DRIVE;
               vec_nxt   = '0;
               busy_nxt  = 1'b1;
               done_nxt  = 1'b0;
               pass_nxt  = 1'b0;
               max_nxt   = '0;
               cnt_nxt   = '0;
               sum_nxt   = '0;
            end
         end

         DRIVE: begin
            if (abort) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b0;
               pass_nxt  = 1'b0;
            end else begin
               state_nxt = SAMPLE;
            end
         end

         SAMPLE: begin
            if (abort) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b0;
               pass_nxt  = 1'b0;
            end else begin
               max_nxt = max_upd;
               if (err_mag != '0) cnt_nxt = err_count + (N_IN+1)'(1);
               sum_nxt = sum_err + (N_IN+N_OUT)'(err_mag);
               if (vec_out == '1) begin
                  state_nxt = DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  pass_nxt  = ({1'b0, max_upd} <= ET_W);
               end else begin
                  state_nxt = DRIVE;
                  vec_nxt   = vec_out + (N_IN)'(1);
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         vec_out   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         max_err   <= '0;
         err_count <= '0;
         sum_err   <= '0;
      end else begin
         state     <= state_nxt;
         vec_out   <= vec_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         pass      <= pass_nxt;
         max_err   <= max_nxt;
         err_count <= cnt_nxt;
         sum_err   <= sum_nxt;
      end
   end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Randomized self-checking bench for approx_err_monitor; circuit outputs come from
// lookup tables indexed by vec_out and expectations from a plain-arithmetic model.
module tb_approx_err_monitor;

   localparam int N_IN  = 4;
   localparam int N_OUT = 2;
   localparam int ET    = 1;
   localparam int NV    = 1 << N_IN;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  start = 1'b0;
   logic                  abort = 1'b0;
   logic [N_IN-1:0]       vec_out;
   logic [N_OUT-1:0]      approx_in, exact_in;
   logic                  busy, done, pass;
   logic [N_OUT-1:0]      max_err;
   logic [N_IN:0]         err_count;
   logic [N_IN+N_OUT-1:0] sum_err;

   logic [N_OUT-1:0] approx_tbl [NV];
   logic [N_OUT-1:0] exact_tbl  [NV];

   int n_tests = 0;
   int n_fail  = 0;
   int exp_max, exp_cnt, exp_sum, exp_pass;

   assign approx_in = approx_tbl[vec_out];
   assign exact_in  = exact_tbl[vec_out];

   approx_err_monitor #(.N_IN(N_IN), .N_OUT(N_OUT), .ET(ET)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .vec_out(vec_out), .approx_in(approx_in), .exact_in(exact_in),
      .busy(busy), .done(done), .max_err(max_err),
      .err_count(err_count), .sum_err(sum_err), .pass(pass)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Statistics over the first n vectors of the current tables.
   task automatic model(input int n);
      int a, b, e;
      exp_max = 0; exp_cnt = 0; exp_sum = 0;
      for (int v = 0; v < n; v++) begin
         a = int'(approx_tbl[v]);
         b = int'(exact_tbl[v]);
         e = (a > b) ? a - b : b - a;
         if (e > exp_max) exp_max = e;
         if (e != 0) exp_cnt++;
         exp_sum += e;
      end
      exp_pass = (exp_max <= ET) ? 1 : 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_equal();
      for (int v = 0; v < NV; v++) begin
         exact_tbl[v]  = N_OUT'($urandom_range(0, (1 << N_OUT) - 1));
         approx_tbl[v] = exact_tbl[v];
      end
   endtask

   task automatic fill_random();
      for (int v = 0; v < NV; v++) begin
         exact_tbl[v]  = N_OUT'($urandom_range(0, (1 << N_OUT) - 1));
         approx_tbl[v] = N_OUT'($urandom_range(0, (1 << N_OUT) - 1));
      end
   endtask

   // Full sweep; the accept edge counts as edge 1, so done must rise on edge 2*NV+1.
   // mid_start > 0 pulses start during the sweep at that edge count.
   task automatic run_sweep(input string tag, input int mid_start);
      int edges;
      model(NV);
      start = 1'b1;
      tick();
      start = 1'b0;
      edges = 1;
      check_val({tag, "_busy_at_accept"}, int'(busy), 1);
      check_val({tag, "_cnt_cleared"}, int'(err_count), 0);
      while (!done && edges < 200) begin
         start = (edges == mid_start) ? 1'b1 : 1'b0;
         tick();
         edges++;
      end
      start = 1'b0;
      check_val({tag, "_edges"}, edges, 2 * NV + 1);
      check_val({tag, "_done"}, int'(done), 1);
      check_val({tag, "_busy"}, int'(busy), 0);
      check_val({tag, "_max"}, int'(max_err), exp_max);
      check_val({tag, "_cnt"}, int'(err_count), exp_cnt);
      check_val({tag, "_sum"}, int'(sum_err), exp_sum);
      check_val({tag, "_pass"}, int'(pass), exp_pass);
      check_val({tag, "_vec"}, int'(vec_out), NV - 1);
   endtask

   initial begin
      fill_equal();
      tick();
      tick();
      check_val("rst_vec", int'(vec_out), 0);
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_done", int'(done), 0);
      check_val("rst_max", int'(max_err), 0);
      check_val("rst_cnt", int'(err_count), 0);
      check_val("rst_sum", int'(sum_err), 0);
      check_val("rst_pass", int'(pass), 0);
      rst = 1'b0;
      tick();

      run_sweep("equal", 0);

      fill_equal();
      exact_tbl[5] = 2'd1; approx_tbl[5] = 2'd3;
      run_sweep("vec5", 0);

      fill_equal();
      foreach (exact_tbl[v]) if (v == 2 || v == 7 || v == 12) begin
         exact_tbl[v]  = 2'd1;
         approx_tbl[v] = (v == 7) ? 2'd0 : 2'd2;
      end
      run_sweep("off1", 0);

      for (int v = 0; v < NV; v++) begin
         exact_tbl[v] = 2'd0; approx_tbl[v] = 2'd3;
      end
      run_sweep("worst", 0);

      for (int r = 0; r < 4; r++) begin
         fill_random();
         run_sweep($sformatf("rand%0d", r), 0);
      end

      // abort / start are ignored or prioritised correctly in DONE
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("done_abort_ignored", int'(done), 1);
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check_val("done_start_wins_busy", int'(busy), 1);
      check_val("done_start_wins_done", int'(done), 0);
      check_val("done_start_wins_pass", int'(pass), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // abort on edge 10: vectors 0..3 were sampled on edges 3,5,7,9
      fill_random();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 2; e < 10; e++) tick();
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      model(4);
      check_val("abort_busy", int'(busy), 0);
      check_val("abort_done", int'(done), 0);
      check_val("abort_pass", int'(pass), 0);
      check_val("abort_max", int'(max_err), exp_max);
      check_val("abort_cnt", int'(err_count), exp_cnt);
      check_val("abort_sum", int'(sum_err), exp_sum);
      tick();
      check_val("abort_idle_hold", int'(busy), 0);
      run_sweep("after_abort", 0);

      // reset on edge 20 of a sweep
      fill_random();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 2; e < 20; e++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("midrst_vec", int'(vec_out), 0);
      check_val("midrst_busy", int'(busy), 0);
      check_val("midrst_done", int'(done), 0);
      check_val("midrst_max", int'(max_err), 0);
      check_val("midrst_cnt", int'(err_count), 0);
      check_val("midrst_sum", int'(sum_err), 0);
      check_val("midrst_pass", int'(pass), 0);

      fill_random();
      run_sweep("midstart", 12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
